pipe_ctrl: RTL

Pipeline control unit for the five-stage core. It generates the per-stage stall vector and the flush/redirect for all inter-stage registers: pc, if_id, id_ex, ex_mem and mem_wb. It sequences multi-cycle EX operations such as madd/msub and div with a cycle counter, and gives exceptions signalled from MEM priority over all stalls. It also keeps saturating stall and flush statistics for debug.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl_if.sv | 41 ++++
 rtl/pipe_ctrl_sat_counter.sv | 22 ++
 rtl/pipe_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stall encodings,
// redirect constants, NOP values and the multi-cycle sequencer states.
package pipe_ctrl_pkg;

    localparam int unsigned STALL_W = 6;

    // Stall bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

    localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;
    localparam logic [31:0] ERET_CODE  = 32'h0000_000e;

    // Values the inter-stage registers take on flush
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] NOP_PC   = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE,
        ST_MC_BUSY
    } mc_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bus between the pipeline stages and pipe_ctrl: requests and
// multi-cycle handshake in, stall/flush/redirect and statistics out.
interface pipe_ctrl_if #(
    parameter int unsigned MC_CNT_W = 6
);
    import pipe_ctrl_pkg::*;

    logic                 stallreq_from_id;
    logic                 stallreq_from_ex;
    logic                 ex_mc_start;
    logic [MC_CNT_W-1:0]  ex_mc_len;
    logic [31:0]          mem_excepttype;
    logic [31:0]          cp0_epc;
    logic                 cnt_clr;

    logic [STALL_W-1:0]   stall;
    logic                 flush;
    logic [31:0]          new_pc;
    logic                 ex_mc_busy;
    logic                 ex_mc_done;
    logic                 ex_mc_cancel;
    logic [31:0]          stall_cycles;
    logic [15:0]          flush_count;

    // Pipeline side
    modport master (
        output stallreq_from_id, stallreq_from_ex, ex_mc_start, ex_mc_len,
               mem_excepttype, cp0_epc, cnt_clr,
        input  stall, flush, new_pc, ex_mc_busy, ex_mc_done, ex_mc_cancel,
               stall_cycles, flush_count
    );

    // Controller side
    modport slave (
        input  stallreq_from_id, stallreq_from_ex, ex_mc_start, ex_mc_len,
               mem_excepttype, cp0_epc, cnt_clr,
        output stall, flush, new_pc, ex_mc_busy, ex_mc_done, ex_mc_cancel,
               stall_cycles, flush_count
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/flush/redirect decode, multi-cycle EX sequencing
// and saturating stall/flush statistics.
module pipe_ctrl #(
    parameter int unsigned MC_CNT_W   = 6,
    parameter logic [31:0] EXC_VECTOR = pipe_ctrl_pkg::EXC_VECTOR,
    parameter logic [31:0] ERET_CODE  = pipe_ctrl_pkg::ERET_CODE
) (
    input  logic     clk,
    input  logic     rst,
    pipe_ctrl_if.slave bus
);
    import pipe_ctrl_pkg::*;

    localparam logic [MC_CNT_W-1:0] MC_ONE = 1;

    mc_state_e           state;
    logic [MC_CNT_W-1:0] mc_cnt;
    logic                busy_q;

    logic                exc;
    logic                mc_accept;
    logic                mc_running;
    logic                ex_stall;
    logic [STALL_W-1:0]  stall_vec;
    logic [31:0]         redirect;

    always_comb begin
        exc        = (bus.mem_excepttype != '0);
        mc_accept  = (state == ST_IDLE) && bus.ex_mc_start &&
                     (bus.ex_mc_len != '0) && !exc;
        mc_running = (state == ST_MC_BUSY) && (mc_cnt != '0);
        ex_stall   = bus.stallreq_from_ex || mc_running || mc_accept;

        // Exception in MEM outranks every stall cause
        if (exc) begin
            stall_vec = STALL_NONE;
        end else if (ex_stall) begin
            stall_vec = STALL_EX;
        end else if (bus.stallreq_from_id) begin
            stall_vec = STALL_ID;
        end else begin
            stall_vec = STALL_NONE;
        end

        if (!exc) begin
            redirect = NOP_PC;
        end else if (bus.mem_excepttype == ERET_CODE) begin
            redirect = bus.cp0_epc;
        end else begin
            redirect = EXC_VECTOR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            mc_cnt <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mc_accept) begin
                        state  <= ST_MC_BUSY;
                        mc_cnt <= bus.ex_mc_len - MC_ONE;
                        busy_q <= 1'b1;
                    end
                end
                ST_MC_BUSY: begin
                    if (exc || (mc_cnt == '0)) begin
                        state  <= ST_IDLE;
                        mc_cnt <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        mc_cnt <= mc_cnt - MC_ONE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    mc_cnt <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall        = stall_vec;
    assign bus.flush        = exc;
    assign bus.new_pc       = redirect;
    assign bus.ex_mc_busy   = busy_q;
    assign bus.ex_mc_done   = (state == ST_MC_BUSY) && (mc_cnt == '0) && !exc;
    assign bus.ex_mc_cancel = (state == ST_MC_BUSY) && exc;

    sat_counter #(
        .W (32)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.cnt_clr),
        .inc   (stall_vec != STALL_NONE),
        .count (bus.stall_cycles)
    );

    sat_counter #(
        .W (16)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.cnt_clr),
        .inc   (exc),
        .count (bus.flush_count)
    );

endmodule
